// File: rtl/tdm_demux.sv
// ============================================================================
// Module   : tdm_demux
// Purpose  : 1-to-CHANNELS time-division demultiplexer with atomic frame shadow
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tdm_demux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          din,
  input  logic                      din_valid,
  input  logic                      sof,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic [CHANNELS-1:0]       dout_valid,
  output logic [CHANNELS*WIDTH-1:0] frame_out,
  output logic                      frame_valid,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int IDX_W = $clog2(CHANNELS);
  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(CHANNELS - 1);
  localparam logic [IDX_W-1:0] C_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] C_ZERO = '0;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [IDX_W-1:0]          r_idx;
  logic [IDX_W-1:0]          w_idx_nxt;
  logic                      w_wr_en;
  logic [IDX_W-1:0]          w_wr_idx;
  logic                      w_frame_done;
  logic                      w_err;
  logic [CHANNELS-1:0]       w_wr_sel;
  logic [CHANNELS*WIDTH-1:0] w_dout_nxt;

  logic [CHANNELS*WIDTH-1:0] r_dout;
  logic [CHANNELS-1:0]       r_dout_valid;
  logic [CHANNELS*WIDTH-1:0] r_frame_out;
  logic                      r_frame_valid;
  logic                      r_frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= C_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_wr_en      = 1'b0;
    w_wr_idx     = C_ZERO;
    w_frame_done = 1'b0;
    w_err        = 1'b0;
    if (din_valid) begin
      case (r_state)
        S_IDLE: begin
          if (sof) begin
            w_wr_en     = 1'b1;
            w_idx_nxt   = C_ONE;
            w_state_nxt = S_RECV;
          end else begin
            w_err = 1'b1;
          end
        end
        S_RECV: begin
          if (sof) begin
            // Short frame: flag it, then resync on the new frame's first word.
            w_err     = 1'b1;
            w_wr_en   = 1'b1;
            w_idx_nxt = C_ONE;
          end else begin
            w_wr_en  = 1'b1;
            w_wr_idx = r_idx;
            if (r_idx == C_LAST) begin
              w_frame_done = 1'b1;
              w_idx_nxt    = C_ZERO;
              w_state_nxt  = S_IDLE;
            end else begin
              w_idx_nxt = r_idx + C_ONE;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = C_ZERO;
        end
      endcase
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    localparam logic [IDX_W-1:0] C_K = IDX_W'(k);
    assign w_wr_sel[k] = w_wr_en && (w_wr_idx == C_K);
    assign w_dout_nxt[k*WIDTH +: WIDTH] = w_wr_sel[k] ? din : r_dout[k*WIDTH +: WIDTH];
  end

  // The shadow takes the next-state view so the closing word lands on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout        <= '0;
      r_dout_valid  <= '0;
      r_frame_out   <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_dout        <= w_dout_nxt;
      r_dout_valid  <= w_wr_sel;
      r_frame_valid <= w_frame_done;
      r_frame_err   <= w_err;
      if (w_frame_done) begin
        r_frame_out <= w_dout_nxt;
      end
    end
  end

  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;
  assign frame_out   = r_frame_out;
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;
  assign busy        = (r_state == S_RECV);

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux.sv
// ============================================================================
// Module   : tb_tdm_demux
// Purpose  : scoreboard bench driving a 4-channel and a 3-channel tdm_demux
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       sof;

  logic [31:0] dout0, fo0;
  logic [3:0]  dv0;
  logic        fv0, fe0, busy0;
  logic [23:0] dout1, fo1;
  logic [2:0]  dv1;
  logic        fv1, fe1, busy1;

  tdm_demux #(.WIDTH(8), .CHANNELS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
    .dout(dout0), .dout_valid(dv0), .frame_out(fo0), .frame_valid(fv0),
    .frame_err(fe0), .busy(busy0)
  );

  tdm_demux #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
    .dout(dout1), .dout_valid(dv1), .frame_out(fo1), .frame_valid(fv1),
    .frame_err(fe1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dout;
    logic [3:0]  dv;
    logic [31:0] fo;
    logic        fv;
    logic        fe;
    logic        busy;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t m_cur[2];
  logic [7:0] m_ch[2][4];
  int   m_len[2];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_len[d] = 0;
      for (int k = 0; k < 4; k++) m_ch[d][k] = 8'h00;
      m_cur[d].dout = '0; m_cur[d].dv = '0; m_cur[d].fo = '0;
      m_cur[d].fv = 1'b0; m_cur[d].fe = 1'b0; m_cur[d].busy = 1'b0;
    end
  endtask

  // Frame-level view: m_len counts words collected in the current frame.
  task automatic model_step(input int d, input logic v, input logic s,
                            input logic [7:0] w, output exp_t e);
    int nch   = (d == 0) ? 4 : 3;
    bit fdone = 1'b0;
    e = m_cur[d];
    e.dv = '0; e.fv = 1'b0; e.fe = 1'b0;
    if (v) begin
      if (s) begin
        if (m_len[d] > 0) e.fe = 1'b1;
        m_ch[d][0] = w;
        e.dv[0]    = 1'b1;
        m_len[d]   = 1;
      end else if (m_len[d] == 0) begin
        e.fe = 1'b1;
      end else begin
        m_ch[d][m_len[d]] = w;
        e.dv[m_len[d]]    = 1'b1;
        m_len[d]++;
        if (m_len[d] == nch) begin
          fdone    = 1'b1;
          m_len[d] = 0;
        end
      end
    end
    e.dout = '0;
    for (int k = 0; k < nch; k++) e.dout[k*8 +: 8] = m_ch[d][k];
    if (fdone) begin
      e.fo = e.dout;
      e.fv = 1'b1;
    end
    e.busy = (m_len[d] > 0);
  endtask

  task automatic step(input logic v, input logic s, input logic [7:0] w);
    exp_t e0, e1;
    din = w; din_valid = v; sof = s;
    model_step(0, v, s, w, e0);
    model_step(1, v, s, w, e1);
    @(posedge clk);
    #1;
    m_cur[0] = e0;
    m_cur[1] = e1;
    if (e0.dv != 0 || e0.fv || e0.fe) q0.push_back(e0);
    if (e1.dv != 0 || e1.fv || e1.fe) q1.push_back(e1);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  task automatic chk(input int d, input logic [31:0] dout_a, input logic [3:0] dv_a,
                     input logic [31:0] fo_a, input logic fv_a, input logic fe_a,
                     input logic busy_a);
    exp_t e;
    if (dv_a != 0 || fv_a || fe_a) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_strobe dut%0d t=%0t: dv=%b fv=%b fe=%b, required no strobe",
                 d, $time, dv_a, fv_a, fe_a);
        return;
      end
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
    end else begin
      e = m_cur[d];
    end
    n_chk++;
    if (dout_a !== e.dout || dv_a !== e.dv || fo_a !== e.fo || fv_a !== e.fv ||
        fe_a !== e.fe || busy_a !== e.busy) begin
      n_fail++;
      $display("FAIL outputs dut%0d t=%0t: got dout=%h dv=%b fo=%h fv=%b fe=%b busy=%b, required dout=%h dv=%b fo=%h fv=%b fe=%b busy=%b",
               d, $time, dout_a, dv_a, fo_a, fv_a, fe_a, busy_a,
               e.dout, e.dv, e.fo, e.fv, e.fe, e.busy);
    end
  endtask

  always @(negedge clk) begin
    chk(0, dout0, dv0, fo0, fv0, fe0, busy0);
    chk(1, {8'h00, dout1}, {1'b0, dv1}, {8'h00, fo1}, fv1, fe1, busy1);
  end

  task automatic do_reset();
    @(negedge clk);
    #1;
    din_valid = 1'b0; sof = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if ({dout0, dv0, fo0, fv0, fe0, busy0} !== '0 ||
        {dout1, dv1, fo1, fv1, fe1, busy1} !== '0) begin
      n_fail++;
      $display("FAIL async_reset t=%0t: got dout4=%h fo4=%h busy4=%b dout3=%h fo3=%h busy3=%b, required all zero",
               $time, dout0, fo0, busy0, dout1, fo1, busy1);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; din = '0; din_valid = 1'b0; sof = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    gap(2);

    // Back-to-back frame
    step(1, 1, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h33); step(1, 0, 8'h44);
    gap(2);

    // Same frame with gaps
    step(1, 1, 8'h11); gap(1); step(1, 0, 8'h22); gap(3);
    step(1, 0, 8'h33); gap(1); step(1, 0, 8'h44);
    gap(2);

    // Short frame then complete frame
    step(1, 1, 8'hA1); step(1, 0, 8'hA2);
    step(1, 1, 8'hB1); step(1, 0, 8'hB2); step(1, 0, 8'hB3); step(1, 0, 8'hB4);
    gap(2);

    // Orphan word
    step(1, 0, 8'h55);
    gap(2);

    // Reset mid-frame, then a clean frame
    step(1, 1, 8'h01); step(1, 0, 8'h02);
    do_reset();
    step(1, 1, 8'h01); step(1, 0, 8'h02); step(1, 0, 8'h03); step(1, 0, 8'h04);
    gap(2);

    // Three-channel wrap check
    step(1, 1, 8'h0A); step(1, 0, 8'h0B); step(1, 0, 8'h0C); step(1, 1, 8'h0D);
    step(1, 0, 8'h0E); step(1, 0, 8'h0F);
    gap(2);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 3), 8'($urandom));
    end
    gap(3);

    n_chk++;
    if (q0.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events dut0: got %0d unobserved strobes, required 0", q0.size());
    end
    n_chk++;
    if (q1.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events dut1: got %0d unobserved strobes, required 0", q1.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Sequential 1-to-N time-division demultiplexer, the receive-side counterpart of the team's 2:1 select/mux cells.
- A single shared word stream carries CHANNELS words per frame, marked by a start-of-frame flag.
- Each accepted word is steered into the register of its channel slot, with a per-channel strobe.
- A complete frame is copied atomically into a shadow frame buffer for downstream logic.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- CHANNELS, 4, words per frame / output channels (>=2).
- IDX_W, $clog2(CHANNELS), slot index width (localparam, derived).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  shared data word.
- din_valid  input  1  din is valid this cycle; no backpressure, every valid word is consumed.
- sof  input  1  start of frame; meaningful only when din_valid=1.
- dout  output  CHANNELS*WIDTH  live channel registers; channel k is dout[k*WIDTH +: WIDTH].
- dout_valid  output  CHANNELS  one-cycle strobe; bit k is high when channel k was just written.
- frame_out  output  CHANNELS*WIDTH  shadow copy of the last complete frame, same slicing as dout.
- frame_valid  output  1  one-cycle pulse when frame_out updates.
- frame_err  output  1  one-cycle pulse on a protocol error.
- busy  output  1  high while in RECV.

Behaviour:
- Reset (rst_n low, asynchronous), takes effect immediately:
  - state=IDLE, idx=0.
  - dout, frame_out, dout_valid, frame_valid and frame_err all 0; busy=0.
- Release of reset: synchronous to clk; first accept possible on the first rising edge after release.
- States: IDLE (waiting for sof), RECV (idx = next slot, 1..CHANNELS-1).
- din_valid=0: no state, idx or data change; all strobes 0 next cycle; gaps of any length are allowed mid-frame.
- IDLE & din_valid & sof:
  - write din to ch0, dout_valid[0]=1 next cycle;
  - idx<=1, state<=RECV.
- IDLE & din_valid & !sof (orphan word):
  - word dropped, no dout change;
  - frame_err=1 next cycle; stay IDLE.
- RECV & din_valid & !sof:
  - write din to ch[idx], dout_valid[idx]=1 next cycle;
  - if idx==CHANNELS-1: frame_out<=all channels including this word (same edge), frame_valid=1 next cycle, idx<=0, state<=IDLE;
  - else idx<=idx+1.
- RECV & din_valid & sof (short frame):
  - frame_err=1 next cycle; frame_out not updated;
  - din written to ch0, dout_valid[0]=1, idx<=1, stay RECV (resync on the new frame).
- Latency: one cycle from accepting edge to visible dout slice/strobe.
  - frame_valid coincides with dout_valid[CHANNELS-1].
  - frame_out is stable from that cycle until the next complete frame.
- Channels not written in a cycle hold their value.
  - dout may show a mix of old and new frames mid-frame; frame_out never does.
- At most one dout_valid bit is high per cycle.
  - frame_valid and frame_err are never high in the same cycle.
- busy = (state==RECV), registered.
- Reset mid-frame: partial frame abandoned; frame_out cleared to 0; no pulses.
- idx never exceeds CHANNELS-1; non-power-of-2 CHANNELS must wrap at CHANNELS-1, not at 2^IDX_W-1.

Test Plan:
- WIDTH=8, CHANNELS=4; back-to-back valid words 0x11(sof), 0x22, 0x33, 0x44:
  - dout_valid = 0001, 0010, 0100, 1000 on consecutive cycles;
  - frame_valid with the 1000 strobe; frame_out=0x44332211; frame_err never high.
- Same frame with din_valid=0 gaps of 1 and 3 cycles between words:
  - identical dout/frame_out results; strobes only one cycle after each valid word; busy high throughout the gaps.
- Short frame 0xA1(sof), 0xA2, 0xB1(sof), 0xB2, 0xB3, 0xB4:
  - frame_err pulse one cycle after 0xB1; frame_out unchanged until 0xB4;
  - then frame_out=0xB4B3B2B1, frame_valid=1.
- Orphan word 0x55 (din_valid=1, sof=0) while in IDLE:
  - frame_err pulse; dout unchanged; state stays IDLE (busy=0).
- Reset mid-frame: assert rst_n=0 after two words of a frame:
  - outputs go to 0 without waiting for clk;
  - after release, a full new frame 0x01..0x04 yields frame_out=0x04030201.
- CHANNELS=3 rerun with 0x0A(sof), 0x0B, 0x0C, then 0x0D(sof):
  - frame_valid after 0x0C; 0x0D lands in ch0 (no wrap to an illegal idx 3);
  - no frame_err raised.
